serial_slave_port_v3: RTL
=========================

Name: serial_slave_port_v3

Overview:
- Parametrised bit-serial bus slave with a word-addressed local memory of configurable depth, mapped at a configurable base address.
- Receives address and write data MSB-first over wr_bus under a valid/ready handshake, and returns read data MSB-first over rd_bus.
- Adds address-range decode, an error response, and backpressure on both directions.
- Sits behind the bus arbiter as one of several slaves on the shared serial bus.

Parameters:
- ADDR_WIDTH, 16, width of the serial address field in bits.
- DATA_WIDTH, 8, width of the data word in bits.
- MEM_DEPTH, 64, number of words in local memory; must be a power of 2 and <= 2**ADDR_WIDTH.
- BASE_ADDR, 0, first bus address mapped to memory word 0; must be aligned to MEM_DEPTH.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- rstn  input  1  reset, synchronous, active-low.
- mode  input  1  transaction type, 1 = write, 0 = read; sampled in the IDLE cycle where master_valid=1.
- wr_bus  input  1  serial address/write-data bit from the master.
- master_valid  input  1  wr_bus carries a valid bit; in IDLE also requests a transaction.
- master_ready  input  1  master accepts the current rd_bus bit.
- rd_bus  output  1  serial read-data bit to the master.
- slave_ready  output  1  slave accepts a wr_bus bit this cycle.
- slave_valid  output  1  rd_bus carries a valid read bit.
- slave_err  output  1  one-cycle pulse marking the end of a transaction whose address was out of range.

Behaviour:
- Reset: rd_bus=0, slave_ready=0, slave_valid=0, slave_err=0; state=IDLE; counters and shift registers cleared. Memory contents are not reset.
- Reset mid-transaction aborts the transaction: no memory write, no slave_err pulse, next state IDLE.
- Transfer rules:
  - An input bit transfers on an edge where slave_ready & master_valid.
  - An output bit transfers on an edge where slave_valid & master_ready.
  - rd_bus is held stable until its bit transfers.
- IDLE: slave_ready=0. If master_valid=1, latch mode and go to ADDR. The wr_bus bit in this cycle is ignored.
- ADDR: slave_ready=1. Each transferred bit shifts into the address register MSB-first. Once ADDR_WIDTH bits have transferred, go to WDATA if the latched mode=1, else RLOAD. master_valid=0 stalls the state without penalty.
- WDATA: slave_ready=1. Shift in DATA_WIDTH bits MSB-first, then go to WRITE.
- WRITE: one cycle, slave_ready=0. If the address is in range, write mem[addr-BASE_ADDR]=data; otherwise leave memory unchanged. Go to DONE.
- RLOAD: one cycle, slave_ready=0. Load the read shift register with mem[addr-BASE_ADDR] if in range, else all-zero. Go to RDATA.
- RDATA: slave_valid=1, rd_bus=shift register MSB. Each transferred bit shifts left. After DATA_WIDTH transfers, go to DONE.
- DONE: one cycle, slave_valid=0, slave_ready=0. slave_err=1 iff the address was out of range. Go to IDLE.
- Range rule: in range iff BASE_ADDR <= addr < BASE_ADDR+MEM_DEPTH. Compare in ADDR_WIDTH+1 bits so no wrap-around occurs. The memory index is the low $clog2(MEM_DEPTH) bits of addr.
- Minimum latency with no stalls:
  - Write: 1 + ADDR_WIDTH + DATA_WIDTH + 2 cycles from IDLE detect back to IDLE.
  - Read: 1 + ADDR_WIDTH + 1 + DATA_WIDTH + 1 cycles.
- Bit counter width is $clog2(max(ADDR_WIDTH,DATA_WIDTH)+1). The counter clears on every state entry.
- mode changes after the IDLE sample are ignored until the next transaction.

Optional Feature:
- Macro: SERIAL_SLAVE_PARITY_EN.
- When defined:
  - Writes: after the DATA_WIDTH data bits, WDATA accepts one extra bit, the even parity over address and data. On mismatch, WRITE suppresses the memory write and DONE pulses slave_err.
  - Reads: RDATA sends one extra bit after the data, the even parity of the data word.
- When undefined: no parity bits in either direction; timing exactly as in Behaviour.

Test Plan (ADDR_WIDTH=12, DATA_WIDTH=8, MEM_DEPTH=64, BASE_ADDR=0x100):
- Write 0xA5 to 0x105 with master_valid held high -> slave_ready high for exactly 20 cycles, slave_err=0 in DONE. A following read of 0x105 with master_ready=1 returns bits 1,0,1,0,0,1,0,1 on 8 slave_valid cycles.
- Write 0x3C to out-of-range 0x0FF, then read 0x0FF -> slave_err=1 for one cycle in each DONE, read data 0x00, mem[0x3F] unchanged.
- Read of 0x13F with master_ready toggling 1,0,1,0 -> rd_bus stable during stall cycles, exactly 8 bits transferred, word returned intact.
- Write with master_valid deasserted for 3 cycles mid-address -> stall without bit loss, correct word written at the intended address.
- Assert rstn=0 during WDATA of a write to 0x110 -> all outputs 0 next cycle, mem[0x10] unchanged, next transaction completes normally.
- With SERIAL_SLAVE_PARITY_EN: write with a wrong parity bit -> no memory write, slave_err pulse. Read of 0xA5 -> 9th bit is 0.

Source files
------------

// File: rtl/serial_slave_port_v3.sv
// Bit-serial bus slave with range-decoded local memory.
// Optional parity on both directions: define SERIAL_SLAVE_PARITY_EN.
module serial_slave_port_v3 #(
  parameter int          ADDR_WIDTH = 16,
  parameter int          DATA_WIDTH = 8,
  parameter int          MEM_DEPTH  = 64,
  parameter int unsigned BASE_ADDR  = 0
) (
  input  logic clk,
  input  logic rstn,
  input  logic mode,
  input  logic wr_bus,
  input  logic master_valid,
  input  logic master_ready,
  output logic rd_bus,
  output logic slave_ready,
  output logic slave_valid,
  output logic slave_err
);

`ifdef SERIAL_SLAVE_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int RW   = DATA_WIDTH + PB;
  localparam int MAXB = (ADDR_WIDTH > RW) ? ADDR_WIDTH : RW;
  localparam int CW   = $clog2(MAXB + 1);
  localparam int IW   = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  localparam logic [ADDR_WIDTH:0] LO =
    (ADDR_WIDTH+1)'(BASE_ADDR);
  localparam logic [ADDR_WIDTH:0] HI =
    (ADDR_WIDTH+1)'(BASE_ADDR + MEM_DEPTH);

  typedef enum logic [2:0] {
    IDLE, ADDR, WDATA, WRITE, RLOAD, RDATA, DONE
  } state_t;

  state_t state_q, state_n;

  logic [CW-1:0]         cnt_q;
  logic                  mode_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [RW-1:0]         rsh_q;
  logic                  perr_q;

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  logic                  in_xfer;
  logic                  out_xfer;
  logic                  in_range;
  logic [IW-1:0]         idx;
  logic [DATA_WIDTH-1:0] mem_rd;
  logic [RW-1:0]         rd_word;

  assign in_xfer  = slave_ready & master_valid;
  assign out_xfer = slave_valid & master_ready;
  assign in_range = ({1'b0, addr_q} >= LO) &&
                    ({1'b0, addr_q} < HI);
  assign idx      = addr_q[IW-1:0];
  assign mem_rd   = in_range ? mem[idx] : '0;
`ifdef SERIAL_SLAVE_PARITY_EN
  assign rd_word  = {mem_rd, ^mem_rd};
`else
  assign rd_word  = mem_rd;
`endif

  // Next-state decode and Moore outputs.
  always_comb begin
    state_n     = state_q;
    slave_ready = 1'b0;
    slave_valid = 1'b0;
    slave_err   = 1'b0;
    rd_bus      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (master_valid) state_n = ADDR;
      end
      ADDR: begin
        slave_ready = 1'b1;
        if (in_xfer && cnt_q == CW'(ADDR_WIDTH-1))
          state_n = mode_q ? WDATA : RLOAD;
      end
      WDATA: begin
        slave_ready = 1'b1;
        if (in_xfer && cnt_q == CW'(RW-1))
          state_n = WRITE;
      end
      WRITE: state_n = DONE;
      RLOAD: state_n = RDATA;
      RDATA: begin
        slave_valid = 1'b1;
        rd_bus      = rsh_q[RW-1];
        if (out_xfer && cnt_q == CW'(RW-1))
          state_n = DONE;
      end
      DONE: begin
        slave_err = ~in_range | perr_q;
        state_n   = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // State register and bit counter; counter clears on state entry.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_n;
      if (state_n != state_q)
        cnt_q <= '0;
      else if (in_xfer | out_xfer)
        cnt_q <= cnt_q + CW'(1);
    end
  end

  // Mode latch, address/data shift-in, read shift-out, parity check.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      mode_q  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rsh_q   <= '0;
      perr_q  <= 1'b0;
    end else begin
      if (state_q == IDLE && master_valid) begin
        mode_q <= mode;
        perr_q <= 1'b0;
      end
      if (state_q == ADDR && in_xfer)
        addr_q <= {addr_q[ADDR_WIDTH-2:0], wr_bus};
      if (state_q == WDATA && in_xfer) begin
        if (cnt_q < CW'(DATA_WIDTH))
          wdata_q <= {wdata_q[DATA_WIDTH-2:0], wr_bus};
`ifdef SERIAL_SLAVE_PARITY_EN
        else
          perr_q <= wr_bus ^ (^{addr_q, wdata_q});
`endif
      end
      if (state_q == RLOAD)
        rsh_q <= rd_word;
      if (state_q == RDATA && out_xfer)
        rsh_q <= {rsh_q[RW-2:0], 1'b0};
    end
  end

  // Memory write; contents are not reset, and reset blocks the write.
  always_ff @(posedge clk) begin
    if (rstn && state_q == WRITE && in_range && !perr_q)
      mem[idx] <= wdata_q;
  end

endmodule
